// File: rtl/burst_shift_register.sv
// burst_shift_register: multi-mode shifter that performs a burst of single-bit
// logical/arithmetic/rotate shifts from one start command, with busy/done
// status and a serial tap of the last bit shifted out.
module burst_shift_register #(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_i,
  input  logic [WIDTH-1:0] word_i,
  input  logic             start_i,
  input  logic [2:0]       op_i,
  input  logic [CNT_W-1:0] amount_i,
  input  logic             serial_i,
  input  logic             abort_i,
  output logic [WIDTH-1:0] out_o,
  output logic             serial_o,
  output logic             busy_o,
  output logic             done_o
);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  localparam logic [2:0] OP_LSL = 3'd0;
  localparam logic [2:0] OP_LSR = 3'd1;
  localparam logic [2:0] OP_ASR = 3'd2;
  localparam logic [2:0] OP_ROL = 3'd3;
  localparam logic [2:0] OP_ROR = 3'd4;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       op_q, op_d;
  logic [WIDTH-1:0] out_q, out_d;
  logic             ser_q, ser_d;
  logic             done_q, done_d;
  logic [CNT_W-1:0] amt;

  assign amt = (amount_i > CNT_W'(WIDTH)) ? CNT_W'(WIDTH) : amount_i;

  // Next-state, datapath and status logic; priority abort > load > start.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    out_d   = out_q;
    ser_d   = ser_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (abort_i) begin
          // drop any load/start this cycle
        end else if (load_i) begin
          out_d = word_i;
        end else if (start_i) begin
          op_d = op_i;
          if (amt == '0) begin
            done_d = 1'b1;
          end else begin
            state_d = SHIFT;
            cnt_d   = amt;
          end
        end
      end
      SHIFT: begin
        if (abort_i) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          case (op_q)
            OP_LSL: begin out_d = {out_q[WIDTH-2:0], serial_i};     ser_d = out_q[WIDTH-1]; end
            OP_LSR: begin out_d = {serial_i, out_q[WIDTH-1:1]};     ser_d = out_q[0];       end
            OP_ASR: begin out_d = {out_q[WIDTH-1], out_q[WIDTH-1:1]}; ser_d = out_q[0];     end
            OP_ROL: begin out_d = {out_q[WIDTH-2:0], out_q[WIDTH-1]}; ser_d = out_q[WIDTH-1]; end
            OP_ROR: begin out_d = {out_q[0], out_q[WIDTH-1:1]};     ser_d = out_q[0];       end
            default: begin end
          endcase
          cnt_d = cnt_q - 1'b1;
          if (cnt_q == CNT_W'(1)) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      op_q    <= '0;
      out_q   <= '0;
      ser_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      out_q   <= out_d;
      ser_q   <= ser_d;
      done_q  <= done_d;
    end
  end

  assign out_o    = out_q;
  assign serial_o = ser_q;
  assign busy_o   = (state_q == SHIFT);
  assign done_o   = done_q;

endmodule

// File: tb/tb_burst_shift_register.sv
// Self-checking bench for burst_shift_register (WIDTH=8): directed scenarios
// plus randomized commands compared every cycle against a burst-level model.
module tb_burst_shift_register;

  localparam int W = 8;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          load_i = 1'b0;
  logic [W-1:0]  word_i = '0;
  logic          start_i = 1'b0;
  logic [2:0]    op_i = '0;
  logic [CW-1:0] amount_i = '0;
  logic          serial_i = 1'b0;
  logic          abort_i = 1'b0;
  logic [W-1:0]  out_o;
  logic          serial_o;
  logic          busy_o;
  logic          done_o;

  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  // model: register, tap, and remaining shifts of the current burst
  int          m_out = 0;
  int          m_ser = 0;
  int          m_left = 0;
  int          m_op = 0;
  int          m_done = 0;

  burst_shift_register #(.WIDTH(W), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .load_i(load_i), .word_i(word_i), .start_i(start_i),
    .op_i(op_i), .amount_i(amount_i), .serial_i(serial_i), .abort_i(abort_i),
    .out_o(out_o), .serial_o(serial_o), .busy_o(busy_o), .done_o(done_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    n_vec++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_out = 0; m_ser = 0; m_left = 0; m_op = 0; m_done = 0;
  endtask

  // One clock edge worth of the specified behaviour.
  task automatic model_edge(input int ld, input int wd, input int st, input int op,
                            input int amt, input int s, input int ab);
    int a;
    m_done = 0;
    if (m_left > 0) begin
      if (ab != 0) begin
        m_left = 0;
      end else begin
        case (m_op)
          0: begin m_ser = (m_out >> 7) & 1; m_out = ((m_out * 2) + s) % 256; end
          1: begin m_ser = m_out & 1; m_out = (m_out / 2) + s * 128; end
          2: begin m_ser = m_out & 1; m_out = (m_out / 2) + (m_out & 128); end
          3: begin m_ser = (m_out >> 7) & 1; m_out = ((m_out * 2) % 256) + (m_out / 128); end
          4: begin m_ser = m_out & 1; m_out = (m_out / 2) + (m_out % 2) * 128; end
          default: begin end
        endcase
        m_left = m_left - 1;
        if (m_left == 0) m_done = 1;
      end
    end else if (ab == 0) begin
      if (ld != 0) begin
        m_out = wd;
      end else if (st != 0) begin
        a = (amt > W) ? W : amt;
        m_op = op;
        if (a == 0) m_done = 1;
        else m_left = a;
      end
    end
  endtask

  task automatic compare_all(input string tag);
    check({tag, ".out"}, int'(out_o), m_out);
    check({tag, ".ser"}, int'(serial_o), m_ser);
    check({tag, ".busy"}, int'(busy_o), (m_left > 0) ? 1 : 0);
    check({tag, ".done"}, int'(done_o), m_done);
  endtask

  task automatic step(input string tag, input int ld, input int wd, input int st,
                      input int op, input int amt, input int s, input int ab);
    load_i = ld[0]; word_i = wd[7:0]; start_i = st[0]; op_i = op[2:0];
    amount_i = amt[3:0]; serial_i = s[0]; abort_i = ab[0];
    @(posedge clk);
    model_edge(ld, wd, st, op, amt, s, ab);
    #1;
    compare_all(tag);
  endtask

  task automatic idle(input string tag);
    step(tag, 0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    int busy_cycles;
    int saw_done;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    compare_all("reset");
    @(negedge clk);
    rst = 1'b0;

    // 1: LSL with serial fill 1
    step("t1.load", 1, 8'hA5, 0, 0, 0, 0, 0);
    step("t1.start", 0, 0, 1, 0, 3, 1, 0);
    step("t1.e1", 0, 0, 0, 0, 0, 1, 0);
    check("t1.v1", int'(out_o), 8'h4B); check("t1.s1", int'(serial_o), 1);
    step("t1.e2", 0, 0, 0, 0, 0, 1, 0);
    check("t1.v2", int'(out_o), 8'h97); check("t1.s2", int'(serial_o), 0);
    step("t1.e3", 0, 0, 0, 0, 0, 1, 0);
    check("t1.v3", int'(out_o), 8'h2F); check("t1.s3", int'(serial_o), 1);
    check("t1.done", int'(done_o), 1); check("t1.busy", int'(busy_o), 0);
    idle("t1.after");
    check("t1.pulse", int'(done_o), 0);

    // 2: ASR sign extension
    step("t2.load", 1, 8'h90, 0, 0, 0, 0, 0);
    step("t2.start", 0, 0, 1, 2, 2, 1, 0);
    repeat (2) idle("t2.run");
    check("t2.v", int'(out_o), 8'hE4); check("t2.s", int'(serial_o), 0);
    check("t2.done", int'(done_o), 1);

    // 3: full rotation, and clamped amount with identical timing
    for (int k = 8; k <= 9; k++) begin
      step("t3.load", 1, 8'h81, 0, 0, 0, 0, 0);
      step("t3.start", 0, 0, 1, 4, k, 0, 0);
      busy_cycles = 1;
      while (busy_o && busy_cycles < 20) begin
        idle("t3.run");
        if (busy_o) busy_cycles++;
      end
      check("t3.busycyc", busy_cycles, 8);
      check("t3.v", int'(out_o), 8'h81); check("t3.done", int'(done_o), 1);
    end

    // 4: zero-length burst, then load+start together
    step("t4.start0", 0, 0, 1, 3, 0, 0, 0);
    check("t4.done", int'(done_o), 1); check("t4.busy", int'(busy_o), 0);
    check("t4.v", int'(out_o), 8'h81);
    step("t4.ldst", 1, 8'h3C, 1, 0, 4, 0, 0);
    check("t4.ld", int'(out_o), 8'h3C); check("t4.noburst", int'(busy_o), 0);

    // 5: abort mid-burst; load/start during the burst are ignored
    step("t5.load", 1, 8'h01, 0, 0, 0, 0, 0);
    step("t5.start", 0, 0, 1, 3, 5, 0, 0);
    step("t5.e1", 1, 8'hFF, 1, 1, 7, 0, 0);
    step("t5.e2", 0, 0, 1, 0, 2, 1, 0);
    step("t5.abort", 0, 0, 0, 0, 0, 0, 1);
    check("t5.v", int'(out_o), 8'h04); check("t5.busy", int'(busy_o), 0);
    check("t5.done", int'(done_o), 0);
    idle("t5.after");

    // 6: back-to-back burst on the done cycle, then async reset mid-burst
    step("t6.start", 0, 0, 1, 1, 2, 1, 0);
    repeat (2) idle("t6.run");
    check("t6.done", int'(done_o), 1);
    step("t6.again", 0, 0, 1, 0, 3, 0, 0);
    check("t6.nogap", int'(busy_o), 1);
    idle("t6.mid");
    #2 rst = 1'b1;
    #1;
    model_reset();
    compare_all("t6.rst");
    @(negedge clk);
    rst = 1'b0;

    // randomized commands
    for (int i = 0; i < 3000; i++) begin
      step("rnd",
           ($urandom_range(0, 9) == 0) ? 1 : 0, int'($urandom_range(0, 255)),
           ($urandom_range(0, 3) == 0) ? 1 : 0, int'($urandom_range(0, 7)),
           int'($urandom_range(0, 15)), int'($urandom_range(0, 1)),
           ($urandom_range(0, 29) == 0) ? 1 : 0);
    end

    // bounded wait for any residual burst to finish
    saw_done = 0;
    for (int i = 0; i < 12 && busy_o; i++) idle("drain");
    check("drain.idle", int'(busy_o), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
